jump_concat: RTL and testbench

JUMP_CONCAT -- requirements
Module: jump_concat

---
 rtl/jump_concat.sv | 35 +++
 tb/tb_jump_concat.sv | 110 +++++++++++
 2 files changed

// File: rtl/jump_concat.sv
// jump_concat: J-type jump target {pc_plus4, ins_28b} with a registered, valid-qualified copy.
module jump_concat #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [27:0] ins_28b,
    input  logic [3:0]  pc_plus4,
    input  logic        in_valid,
    output logic [31:0] jump_address,
    output logic        misaligned,
    output logic [31:0] jump_address_q,
    output logic        out_valid,
    output logic        misaligned_q
);
    logic [31:0] jump_address_d;
    logic        misaligned_d;
    assign jump_address = {pc_plus4, ins_28b};
    assign misaligned   = ALIGN_CHECK ? (ins_28b[1] | ins_28b[0]) : 1'b0;
    always_comb begin
        jump_address_d = in_valid ? jump_address : jump_address_q;
        misaligned_d   = in_valid ? misaligned : misaligned_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_address_q <= 32'h0000_0000;
            out_valid      <= 1'b0;
            misaligned_q   <= 1'b0;
        end else begin
            jump_address_q <= jump_address_d;
            out_valid      <= in_valid;
            misaligned_q   <= misaligned_d;
        end
    end
endmodule

// File: tb/tb_jump_concat.sv
// tb_jump_concat: directed checks of the combinational and registered jump paths.
module tb_jump_concat;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [27:0] ins_28b;
    logic [3:0]  pc_plus4;
    logic        in_valid;
    logic [31:0] ja, jaq, ja0, jaq0;
    logic        mis, misq, ov, mis0, misq0, ov0;
    int          checks = 0;
    int          errors = 0;

    jump_concat #(.ALIGN_CHECK(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .ins_28b(ins_28b), .pc_plus4(pc_plus4), .in_valid(in_valid),
        .jump_address(ja), .misaligned(mis), .jump_address_q(jaq), .out_valid(ov), .misaligned_q(misq)
    );
    jump_concat #(.ALIGN_CHECK(1'b0)) u_noalign (
        .clk(clk), .rst_n(rst_n), .ins_28b(ins_28b), .pc_plus4(pc_plus4), .in_valid(in_valid),
        .jump_address(ja0), .misaligned(mis0), .jump_address_q(jaq0), .out_valid(ov0), .misaligned_q(misq0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; ins_28b = '0; pc_plus4 = '0; in_valid = 1'b0;
        #2;
        chk("rst_jaq", jaq, 32'h0);
        chk("rst_ov", {31'b0, ov}, 32'h0);
        chk("rst_misq", {31'b0, misq}, 32'h0);
        chk("zero_ja", ja, 32'h0);
        chk("zero_mis", {31'b0, mis}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; ins_28b = 28'h0000038; pc_plus4 = 4'h3; in_valid = 1'b1;
        #1;
        chk("ja_38", ja, 32'h3000_0038);
        chk("mis_38", {31'b0, mis}, 32'h0);
        chk("misq_before", {31'b0, misq}, 32'h0);
        @(posedge clk); #1;
        chk("jaq_38", jaq, 32'h3000_0038);
        chk("ov_38", {31'b0, ov}, 32'h1);
        chk("misq_38", {31'b0, misq}, 32'h0);
        @(negedge clk);
        ins_28b = 28'h00000E3; pc_plus4 = 4'h7;
        #1;
        chk("ja_e3", ja, 32'h7000_00E3);
        chk("mis_e3", {31'b0, mis}, 32'h1);
        chk("mis_e3_noalign", {31'b0, mis0}, 32'h0);
        chk("ja_e3_noalign", ja0, 32'h7000_00E3);
        @(posedge clk); #1;
        chk("jaq_e3", jaq, 32'h7000_00E3);
        chk("ov_e3", {31'b0, ov}, 32'h1);
        chk("misq_e3", {31'b0, misq}, 32'h1);
        chk("misq_e3_noalign", {31'b0, misq0}, 32'h0);
        @(negedge clk);
        in_valid = 1'b0; ins_28b = 28'h000001F; pc_plus4 = 4'hF;
        #1;
        chk("ja_1f", ja, 32'hF000_001F);
        chk("mis_1f", {31'b0, mis}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold_jaq", jaq, 32'h7000_00E3);
            chk("hold_ov", {31'b0, ov}, 32'h0);
            chk("hold_misq", {31'b0, misq}, 32'h1);
        end
        @(negedge clk);
        in_valid = 1'b1; ins_28b = 28'hFFF_FFFC; pc_plus4 = 4'hF;
        #1;
        chk("ja_max", ja, 32'hFFFF_FFFC);
        chk("mis_max", {31'b0, mis}, 32'h0);
        @(posedge clk); #1;
        chk("jaq_max", jaq, 32'hFFFF_FFFC);
        chk("misq_max", {31'b0, misq}, 32'h0);
        @(negedge clk);
        ins_28b = 28'h0000005; pc_plus4 = 4'h1;
        @(posedge clk); #1;
        chk("b2b_jaq", jaq, 32'h1000_0005);
        chk("b2b_ov", {31'b0, ov}, 32'h1);
        chk("b2b_misq", {31'b0, misq}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_jaq", jaq, 32'h0);
        chk("midrst_ov", {31'b0, ov}, 32'h0);
        chk("midrst_misq", {31'b0, misq}, 32'h0);
        chk("midrst_ja", ja, 32'h1000_0005);
        chk("midrst_mis", {31'b0, mis}, 32'h1);
        @(posedge clk); #1;
        chk("inrst_jaq", jaq, 32'h0);
        chk("inrst_ov", {31'b0, ov}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; ins_28b = 28'h0ABCDE0; pc_plus4 = 4'h9;
        @(posedge clk); #1;
        chk("post_rst_jaq", jaq, 32'h90AB_CDE0);
        chk("post_rst_ov", {31'b0, ov}, 32'h1);
        @(negedge clk);
        ins_28b = 28'bx; pc_plus4 = 4'h2;
        #1;
        chk("x_ja", ja, {4'h2, 28'bx});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
